// File: rtl/nios_pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit debounce, edge capture,
// per-bit interrupt mask and a level interrupt towards the Nios II.
//
// Register map (word address):
//   0 DATA          RO   debounced input value
//   1 reserved      RO   reads 0, writes ignored
//   2 IRQ_MASK      RW   per-bit interrupt enable
//   3 EDGE_CAPTURE  R/W1C sticky edge flags
// Bits above WIDTH read as 0. readdata is registered (read latency 1).
module nios_pio_in_irq #(
    parameter int              WIDTH           = 4,
    parameter int              SYNC_STAGES     = 2,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter int              EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE    = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter is never narrower than one bit so the bypass build stays legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] cap_clr;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_cap;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Only the low WIDTH bits of writedata carry meaning.
    assign unused_wdata = ^writedata;

    assign wr_en   = chipselect && !write_n;
    assign wr_mask = wr_en && (address == ADDR_MASK);
    assign wr_cap  = wr_en && (address == ADDR_CAP);

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain; stage 0 is the only flop fed by the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            // NOTE: non-blocking assignments in clocked blocks make every stage
            // take the previous-cycle value of its neighbour, giving a real shift.
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-bit debounce: the debounced bit follows the synchronised bit only
    // after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (DEBOUNCE_CYCLES == 0) begin
                deb_d[i] = sync_out[i];
                cnt_d[i] = '0;
            end else if (sync_out[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync_out[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounced value and its per-bit stability counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q <= RESET_VALUE;
            // NOTE: the counter array is reset too, so a count that was in
            // progress when reset arrived is discarded rather than resumed.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Edge detect on the debounced value, fired on the edge deb changes.
    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_evt = deb_d & ~deb_q;
            EDGE_FALL: edge_evt = ~deb_d & deb_q;
            default:   edge_evt = deb_d ^ deb_q;
        endcase
    end

    // Sticky capture: a new event wins over a write-1-to-clear in the same cycle.
    assign cap_clr = writedata[WIDTH-1:0] & {WIDTH{wr_cap}};
    assign cap_d   = edge_evt | (cap_q & ~cap_clr);

    // Mask and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            if (wr_mask) begin
                mask_q <= writedata[WIDTH-1:0];
            end
            cap_q <= cap_d;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = deb_q;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask_q;
            ADDR_CAP:  rd_mux[WIDTH-1:0] = cap_q;
            default:   rd_mux = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_pio_in_irq.sv
// Bench for nios_pio_in_irq. Two instances share clock and reset:
//   a (index 0): DEBOUNCE_CYCLES=4, falling-edge capture
//   b (index 1): debounce bypassed, any-edge capture
// A sample-history reference model tracks both instances every edge.
module tb_nios_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address    [2];
    logic        chipselect [2];
    logic        write_n    [2];
    logic [31:0] writedata  [2];
    logic [3:0]  in_port    [2];
    logic [31:0] readdata   [2];
    logic        irq        [2];

    int total = 0;
    int bad   = 0;

    nios_pio_in_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'hF)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address[0]), .chipselect(chipselect[0]),
        .write_n(write_n[0]), .writedata(writedata[0]), .in_port(in_port[0]),
        .readdata(readdata[0]), .irq(irq[0])
    );

    nios_pio_in_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_VALUE(4'hF)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address[1]), .chipselect(chipselect[1]),
        .write_n(write_n[1]), .writedata(writedata[1]), .in_port(in_port[1]),
        .readdata(readdata[1]), .irq(irq[1])
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist[k][n] is the in_port value sampled n edges ago (0 = this edge).
    // The debouncer sees in_port delayed by SYNC edges, and a bit flips once
    // the last win_len samples it has seen all disagree with the current value.
    localparam int SYNC = 2;
    logic [3:0]  hist   [2][8];
    logic [3:0]  m_deb  [2];
    logic [3:0]  m_cap  [2];
    logic [3:0]  m_mask [2];
    logic [31:0] m_rd   [2];

    function automatic int win_len(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_deb[k]  = 4'hF;
            m_cap[k]  = 4'h0;
            m_mask[k] = 4'h0;
            m_rd[k]   = 32'h0;
            for (int j = 0; j < 8; j++) hist[k][j] = 4'hF;
        end
    endfunction

    function automatic void model_step();
        logic [3:0] nd;
        logic [3:0] ev;
        logic       all_diff;
        logic       wr;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            wr = chipselect[k] && !write_n[k];
            case (address[k])
                2'd0:    m_rd[k] = {28'h0, m_deb[k]};
                2'd2:    m_rd[k] = {28'h0, m_mask[k]};
                2'd3:    m_rd[k] = {28'h0, m_cap[k]};
                default: m_rd[k] = 32'h0;
            endcase
            for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = in_port[k];
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < win_len(k); j++)
                    if (hist[k][SYNC+j][i] == m_deb[k][i]) all_diff = 1'b0;
                nd[i] = all_diff ? ~m_deb[k][i] : m_deb[k][i];
            end
            ev = (k == 0) ? (m_deb[k] & ~nd) : (m_deb[k] ^ nd);
            if (wr && address[k] == 2'd3) m_cap[k] = m_cap[k] & ~writedata[k][3:0];
            m_cap[k] = m_cap[k] | ev;
            if (wr && address[k] == 2'd2) m_mask[k] = writedata[k][3:0];
            m_deb[k] = nd;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_write(input int k, input logic [1:0] a, input logic [31:0] d);
        chipselect[k] = 1'b1;
        write_n[k]    = 1'b0;
        address[k]    = a;
        writedata[k]  = d;
        tick();
        chipselect[k] = 1'b0;
        write_n[k]    = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            total++; if (readdata[k] !== 32'h0) begin bad++; $display("FAIL in_reset_rd[%0d]: got %h want 0", k, readdata[k]); end
            total++; if (irq[k] !== 1'b0) begin bad++; $display("FAIL in_reset_irq[%0d]: got %b want 0", k, irq[k]); end
        end
        reset_n = 1'b1;
        address[0] = 2'd0; address[1] = 2'd0;
        tick();
        for (int k = 0; k < 2; k++) begin
            total++; if (readdata[k] !== 32'h0000000F) begin bad++; $display("FAIL reset_data[%0d]: got %h want 0000000f", k, readdata[k]); end
        end
        address[0] = 2'd3;
        tick();
        total++; if (readdata[0] !== 32'h0) begin bad++; $display("FAIL reset_cap: got %h want 0", readdata[0]); end
        address[0] = 2'd1;
        tick();
        total++; if (readdata[0] !== 32'h0) begin bad++; $display("FAIL reserved_rd: got %h want 0", readdata[0]); end
        do_write(0, 2'd1, 32'hFFFF_FFFF);
        tick();
        total++; if (readdata[0] !== 32'h0) begin bad++; $display("FAIL reserved_after_wr: got %h want 0", readdata[0]); end
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq[0]); end
    endtask

    task automatic test_debounce_latency();
        address[0] = 2'd0;
        in_port[0] = 4'hE;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) begin
                total++; if (readdata[0] !== 32'hF) begin bad++; $display("FAIL deb_early: got %h want 0000000f", readdata[0]); end
            end
            if (e == 7) begin
                total++; if (readdata[0] !== 32'hE) begin bad++; $display("FAIL deb_latency: got %h want 0000000e", readdata[0]); end
            end
        end
        address[0] = 2'd3;
        tick();
        total++; if (readdata[0] !== 32'h1) begin bad++; $display("FAIL cap_masked: got %h want 1", readdata[0]); end
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", irq[0]); end
    endtask

    task automatic test_irq_mask();
        do_write(0, 2'd2, 32'h1);
        total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL irq_on_mask: got %b want 1", irq[0]); end
        tick();
        total++; if (readdata[0] !== 32'h1) begin bad++; $display("FAIL mask_readback: got %h want 1", readdata[0]); end
        do_write(0, 2'd3, 32'h2);
        tick();
        total++; if (readdata[0] !== 32'h1) begin bad++; $display("FAIL cap_other_clr: got %h want 1", readdata[0]); end
        total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL irq_other_clr: got %b want 1", irq[0]); end
        do_write(0, 2'd3, 32'h1);
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_after_clr: got %b want 0", irq[0]); end
        tick();
        total++; if (readdata[0] !== 32'h0) begin bad++; $display("FAIL cap_after_clr: got %h want 0", readdata[0]); end
    endtask

    task automatic test_glitch();
        do_write(0, 2'd2, 32'hF);
        in_port[0] = 4'hC;
        repeat (3) tick();
        in_port[0] = 4'hE;
        for (int c = 0; c < 8; c++) begin
            tick();
            total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL glitch_irq c%0d: got %b want 0", c, irq[0]); end
        end
        address[0] = 2'd0;
        tick();
        total++; if (readdata[0] !== 32'hE) begin bad++; $display("FAIL glitch_deb: got %h want e", readdata[0]); end
        address[0] = 2'd3;
        tick();
        total++; if (readdata[0] !== 32'h0) begin bad++; $display("FAIL glitch_cap: got %h want 0", readdata[0]); end
        in_port[0] = 4'hC;
        repeat (4) tick();
        in_port[0] = 4'hE;
        repeat (10) tick();
        tick();
        total++; if (readdata[0] !== 32'h2) begin bad++; $display("FAIL min_pulse_cap: got %h want 2", readdata[0]); end
        total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL min_pulse_irq: got %b want 1", irq[0]); end
        address[0] = 2'd0;
        tick();
        total++; if (readdata[0] !== 32'hE) begin bad++; $display("FAIL min_pulse_deb: got %h want e", readdata[0]); end
        do_write(0, 2'd3, 32'h2);
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL min_pulse_clr: got %b want 0", irq[0]); end
    endtask

    task automatic test_set_beats_clear();
        in_port[0] = 4'hA;
        repeat (5) tick();
        chipselect[0] = 1'b1; write_n[0] = 1'b0; address[0] = 2'd3; writedata[0] = 32'h4;
        tick();
        chipselect[0] = 1'b0; write_n[0] = 1'b1;
        tick();
        total++; if (readdata[0] !== 32'h4) begin bad++; $display("FAIL set_wins_cap: got %h want 4", readdata[0]); end
        total++; if (irq[0] !== 1'b1) begin bad++; $display("FAIL set_wins_irq: got %b want 1", irq[0]); end
        do_write(0, 2'd3, 32'h4);
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL plain_clr_irq: got %b want 0", irq[0]); end
        tick();
        total++; if (readdata[0] !== 32'h0) begin bad++; $display("FAIL plain_clr_cap: got %h want 0", readdata[0]); end
    endtask

    task automatic test_bypass_any();
        do_write(1, 2'd2, 32'hF);
        for (int pass = 0; pass < 2; pass++) begin
            address[1] = 2'd0;
            in_port[1] = (pass == 0) ? 4'h7 : 4'hF;
            for (int e = 1; e <= 4; e++) begin
                tick();
                if (e == 2) begin
                    total++; if (irq[1] !== 1'b0) begin bad++; $display("FAIL byp_irq_early p%0d: got %b want 0", pass, irq[1]); end
                end
                if (e == 3) begin
                    total++; if (readdata[1] !== ((pass == 0) ? 32'hF : 32'h7)) begin bad++; $display("FAIL byp_deb_early p%0d: got %h", pass, readdata[1]); end
                    total++; if (irq[1] !== 1'b1) begin bad++; $display("FAIL byp_irq p%0d: got %b want 1", pass, irq[1]); end
                end
                if (e == 4) begin
                    total++; if (readdata[1] !== ((pass == 0) ? 32'h7 : 32'hF)) begin bad++; $display("FAIL byp_deb p%0d: got %h", pass, readdata[1]); end
                end
            end
            address[1] = 2'd3;
            tick();
            total++; if (readdata[1] !== 32'h8) begin bad++; $display("FAIL byp_cap p%0d: got %h want 8", pass, readdata[1]); end
            do_write(1, 2'd3, 32'h8);
            total++; if (irq[1] !== 1'b0) begin bad++; $display("FAIL byp_clr p%0d: got %b want 0", pass, irq[1]); end
        end
    endtask

    task automatic test_random();
        int hold [2];
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (hold[k] == 0) begin
                    in_port[k] = 4'($urandom);
                    hold[k]    = int'($urandom_range(1, 8));
                end
                hold[k]--;
                chipselect[k] = ($urandom_range(0, 3) == 0);
                write_n[k]    = 1'($urandom_range(0, 1));
                address[k]    = 2'($urandom_range(0, 3));
                writedata[k]  = $urandom;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++; if (readdata[k] !== m_rd[k]) begin bad++; $display("FAIL rand_rd[%0d] c%0d: got %h want %h", k, c, readdata[k], m_rd[k]); end
                total++; if (irq[k] !== |(m_cap[k] & m_mask[k])) begin bad++; $display("FAIL rand_irq[%0d] c%0d: got %b want %b", k, c, irq[k], |(m_cap[k] & m_mask[k])); end
            end
        end
        chipselect[0] = 1'b0; chipselect[1] = 1'b0;
        write_n[0] = 1'b1; write_n[1] = 1'b1;
    endtask

    task automatic test_reset_mid_count();
        in_port[0] = 4'hF; in_port[1] = 4'hF;
        repeat (12) tick();
        do_write(0, 2'd2, 32'hF); do_write(1, 2'd2, 32'hF);
        do_write(0, 2'd3, 32'hF); do_write(1, 2'd3, 32'hF);
        in_port[0] = 4'h0; in_port[1] = 4'hE;
        repeat (4) tick();
        total++; if (irq[1] !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want 1", irq[1]); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++; if (readdata[k] !== 32'h0) begin bad++; $display("FAIL async_rst_rd[%0d]: got %h want 0", k, readdata[k]); end
            total++; if (irq[k] !== 1'b0) begin bad++; $display("FAIL async_rst_irq[%0d]: got %b want 0", k, irq[k]); end
        end
        in_port[1] = 4'hF;
        repeat (2) tick();
        reset_n = 1'b1;
        address[0] = 2'd0; address[1] = 2'd0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) begin
                total++; if (readdata[0] !== 32'hF) begin bad++; $display("FAIL rst_discard: got %h want f", readdata[0]); end
            end
            if (e == 7) begin
                total++; if (readdata[0] !== 32'h0) begin bad++; $display("FAIL rst_relatch: got %h want 0", readdata[0]); end
                total++; if (readdata[1] !== 32'hF) begin bad++; $display("FAIL rst_deb_b: got %h want f", readdata[1]); end
            end
        end
        address[0] = 2'd3; address[1] = 2'd3;
        tick();
        total++; if (readdata[0] !== 32'hF) begin bad++; $display("FAIL rst_cap_a: got %h want f", readdata[0]); end
        total++; if (readdata[1] !== 32'h0) begin bad++; $display("FAIL rst_cap_b: got %h want 0", readdata[1]); end
        total++; if (irq[0] !== 1'b0) begin bad++; $display("FAIL rst_mask_cleared: got %b want 0", irq[0]); end
    endtask

    initial begin
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            address[k] = 2'd0; chipselect[k] = 1'b0; write_n[k] = 1'b1;
            writedata[k] = 32'h0; in_port[k] = 4'hF;
        end
        model_reset();
        #1 reset_n = 1'b0;
        test_reset();
        test_debounce_latency();
        test_irq_mask();
        test_glitch();
        test_set_beats_clear();
        test_bypass_any();
        test_random();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
